// File: rtl/serial_deser_pkg.sv
// Shared types and constants for the serial deserializer: FSM state encoding,
// bit-counter width helper and the legal WIDTH range.
package serial_deser_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      PARITY  = 1'b1
   } deser_state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

   // Counter must be able to hold WIDTH itself (parity phase parks it there).
   function automatic int cnt_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/deser_shift_reg.sv
// Indexed shift register: loads din into bit position idx on load; clear
// zeroes the whole word and takes priority over load.
module deser_shift_reg #(
   parameter int WIDTH = 8,
   parameter int CW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load,
   input  logic [CW-1:0]    idx,
   input  logic             din,
   output logic [WIDTH-1:0] word
);

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         logic bit_reg;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset)
               bit_reg <= 1'b0;
            else if (clear)
               bit_reg <= 1'b0;
            else if (load && (idx == CW'(gi)))
               bit_reg <= din;
         end

         assign word[gi] = bit_reg;
      end
   endgenerate

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer, LSB first, with a one-word valid/ready holding
// register and sticky overrun flag. Define SERIAL_DESER_PARITY_EN for even parity.
module serial_deserializer
   import serial_deser_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             din,
   input  logic             din_valid,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             overrun,
   output logic             parity_err
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

   generate
      if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
         $error("serial_deserializer: WIDTH out of range 2..32");
      end
   endgenerate

   deser_state_t     state_reg, state_next;
   logic [CW-1:0]    bitcnt_reg, bitcnt_next;
   logic [WIDTH-1:0] dout_reg, dout_next;
   logic             dout_valid_reg, dout_valid_next;
   logic             overrun_reg, overrun_next;
   logic             parity_err_reg, parity_err_next;

   logic [WIDTH-1:0] shift_word;
   logic             shift_load;
   logic             word_done;
   logic [WIDTH-1:0] done_word;
   logic             done_perr;

   deser_shift_reg #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_shift (
      .clk   (Clk),
      .reset (reset),
      .clear (word_done),
      .load  (shift_load),
      .idx   (bitcnt_reg),
      .din   (din),
      .word  (shift_word)
   );

   always_ff @(posedge Clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= COLLECT;
         bitcnt_reg     <= '0;
         dout_reg       <= '0;
         dout_valid_reg <= 1'b0;
         overrun_reg    <= 1'b0;
         parity_err_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         bitcnt_reg     <= bitcnt_next;
         dout_reg       <= dout_next;
         dout_valid_reg <= dout_valid_next;
         overrun_reg    <= overrun_next;
         parity_err_reg <= parity_err_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      bitcnt_next = bitcnt_reg;
      shift_load  = 1'b0;
      word_done   = 1'b0;
      done_word   = shift_word;
      done_perr   = 1'b0;

      if (din_valid) begin
         case (state_reg)
            COLLECT: begin
               shift_load = 1'b1;
               if (bitcnt_reg == LAST_IDX) begin
`ifdef SERIAL_DESER_PARITY_EN
                  state_next  = PARITY;
                  bitcnt_next = CW'(WIDTH);
`else
                  // Last bit is still in flight into the shift register; splice it in.
                  word_done   = 1'b1;
                  bitcnt_next = '0;
                  done_word   = {din, shift_word[WIDTH-2:0]};
`endif
               end else begin
                  bitcnt_next = bitcnt_reg + CW'(1);
               end
            end
`ifdef SERIAL_DESER_PARITY_EN
            PARITY: begin
               word_done   = 1'b1;
               bitcnt_next = '0;
               state_next  = COLLECT;
               done_perr   = (^shift_word) ^ din;
            end
`endif
            default: state_next = COLLECT;
         endcase
      end

      dout_next       = dout_reg;
      dout_valid_next = dout_valid_reg;
      overrun_next    = overrun_reg;
      parity_err_next = parity_err_reg;

      if (word_done) begin
         // Holding register is free if empty or being drained this same edge.
         if (!dout_valid_reg || dout_ready) begin
            dout_next       = done_word;
            dout_valid_next = 1'b1;
            parity_err_next = done_perr;
         end else begin
            overrun_next = 1'b1;
         end
      end else if (dout_valid_reg && dout_ready) begin
         dout_valid_next = 1'b0;
      end
   end

   assign dout       = dout_reg;
   assign dout_valid = dout_valid_reg;
   assign overrun    = overrun_reg;
   assign parity_err = parity_err_reg;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer (WIDTH=8); also covers the parity
// build when SERIAL_DESER_PARITY_EN is defined.
module tb_serial_deserializer;

   localparam int WIDTH = 8;

   logic             Clk = 1'b0;
   logic             reset = 1'b0;
   logic             din = 1'b0;
   logic             din_valid = 1'b0;
   logic             dout_ready = 1'b0;
   logic [WIDTH-1:0] dout;
   logic             dout_valid;
   logic             overrun;
   logic             parity_err;

   typedef struct packed {
      logic [WIDTH-1:0] data;
      logic             perr;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail = 0;
   bit   mon_en = 1'b0;

   serial_deserializer #(.WIDTH(WIDTH)) dut (
      .Clk        (Clk),
      .reset      (reset),
      .din        (din),
      .din_valid  (din_valid),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Handshake completes at the next rising edge; sample it mid-cycle.
   always @(negedge Clk) begin
      if (mon_en && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            check("scoreboard_has_entry", 32'(exp_q.size()), 32'd1);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            $display("accept dout=0x%02h perr=%0b (exp 0x%02h perr=%0b)", dout, parity_err, e.data, e.perr);
            check("word_data", 32'(dout), 32'(e.data));
            check("word_perr", 32'(parity_err), 32'(e.perr));
         end
      end
   end

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      din       = b;
      din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
   endtask

   function automatic logic even_par(input logic [WIDTH-1:0] w);
      return ^w;
   endfunction

   // keep: word is expected to reach the consumer; ready_last raises dout_ready
   // just before the edge that completes the word.
   task automatic send_word(input logic [WIDTH-1:0] w, input bit gaps, input logic pbit,
                            input bit keep, input bit ready_last);
      logic perr_exp;
`ifdef SERIAL_DESER_PARITY_EN
      perr_exp = even_par(w) ^ pbit;
`else
      perr_exp = 1'b0;
`endif
      if (keep) exp_q.push_back({w, perr_exp});
      for (int i = 0; i < WIDTH; i++) begin
         if (gaps && (i % 3 == 1)) tick();
`ifndef SERIAL_DESER_PARITY_EN
         if (ready_last && i == WIDTH - 1) dout_ready = 1'b1;
`endif
         send_bit(w[i]);
      end
`ifdef SERIAL_DESER_PARITY_EN
      if (ready_last) dout_ready = 1'b1;
      send_bit(pbit);
`endif
   endtask

   task automatic do_reset();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         din       = ~din;
         din_valid = ~din_valid;
         tick();
      end
      din_valid = 1'b0;
      reset     = 1'b1;
   endtask

   initial begin
      logic exp_perr7;
      mon_en = 1'b1;

      // Reset held: outputs stay 0 while inputs toggle
      do_reset();
      reset = 1'b0;
      check("rst_dout", 32'(dout), 32'h0);
      check("rst_dout_valid", 32'(dout_valid), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
      check("rst_parity_err", 32'(parity_err), 32'h0);
      reset = 1'b1;
      tick();

      // First qualified bit after release lands in dout[0]
      dout_ready = 1'b1;
      send_word(8'h01, 1'b0, even_par(8'h01), 1'b1, 1'b0);
      check("first_bit_dout0", 32'(dout), 32'h01);
      tick();

      // Single word with gaps, one-edge latency, valid for one cycle
      send_word(8'hA5, 1'b1, even_par(8'hA5), 1'b1, 1'b0);
      check("single_dout", 32'(dout), 32'hA5);
      check("single_valid", 32'(dout_valid), 32'h1);
      check("single_overrun", 32'(overrun), 32'h0);
      tick();
      check("single_valid_drop", 32'(dout_valid), 32'h0);
      check("single_dout_kept", 32'(dout), 32'hA5);

      // Accept and completion on the same edge
      dout_ready = 1'b0;
      send_word(8'h11, 1'b0, even_par(8'h11), 1'b1, 1'b0);
      check("simul_first_held", 32'(dout), 32'h11);
      send_word(8'h22, 1'b0, even_par(8'h22), 1'b1, 1'b1);
      check("simul_dout", 32'(dout), 32'h22);
      check("simul_valid", 32'(dout_valid), 32'h1);
      check("simul_overrun", 32'(overrun), 32'h0);
      tick();
      check("simul_drained", 32'(dout_valid), 32'h0);

      // Backpressure: second word dropped, overrun sticky
      dout_ready = 1'b0;
      send_word(8'h3C, 1'b0, even_par(8'h3C), 1'b1, 1'b0);
      check("bp_overrun_before", 32'(overrun), 32'h0);
      send_word(8'hFF, 1'b1, even_par(8'hFF), 1'b0, 1'b0);
      check("bp_dout_held", 32'(dout), 32'h3C);
      check("bp_valid", 32'(dout_valid), 32'h1);
      check("bp_overrun", 32'(overrun), 32'h1);
      dout_ready = 1'b1;
      tick();
      check("bp_valid_drop", 32'(dout_valid), 32'h0);
      check("bp_overrun_sticky", 32'(overrun), 32'h1);

      // Reset mid-word discards partial bits
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      do_reset();
      check("midrst_overrun", 32'(overrun), 32'h0);
      check("midrst_valid", 32'(dout_valid), 32'h0);
      send_word(8'h81, 1'b0, even_par(8'h81), 1'b1, 1'b0);
      check("midrst_dout", 32'(dout), 32'h81);
      tick();

      // Parity: correct and wrong parity bit (both 0)
      send_word(8'h03, 1'b0, 1'b0, 1'b1, 1'b0);
      check("par_ok", 32'(parity_err), 32'h0);
      send_word(8'h07, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SERIAL_DESER_PARITY_EN
      exp_perr7 = 1'b1;
`else
      exp_perr7 = 1'b0;
`endif
      check("par_err", 32'(parity_err), 32'(exp_perr7));
      tick();
      check("par_err_held", 32'(parity_err), 32'(exp_perr7));

      // Full rate with ready held: no overrun
      for (int k = 0; k < 4; k++) begin
         logic [WIDTH-1:0] w;
         w = WIDTH'($urandom_range(0, 255));
         send_word(w, 1'b0, even_par(w), 1'b1, 1'b0);
      end
      check("fullrate_overrun", 32'(overrun), 32'h0);

      tick();
      tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_deserializer.md
# serial_deserializer

Serial-to-parallel deserializer sitting directly downstream of the flip-flop bit-path stages (JK-based D flip-flop and similar): it consumes the registered serial bit `Q` as `din`, one bit per qualified clock, and assembles `WIDTH`-bit words. Completed words are presented on a valid/ready output port with a one-word holding register. Backpressure overruns are flagged. An optional even-parity bit per word can be compiled in.

## Interface
- `WIDTH`, default 8: data bits per word; legal range 2..32.
- `Clk`  input  1: rising-edge clock, the only clock.
- `reset`  input  1: asynchronous, active-low reset; 0 resets all state immediately.
- `din`  input  1: serial data bit, normally driven from the upstream flip-flop `Q`.
- `din_valid`  input  1: `din` is sampled on a rising edge of `Clk` only when this is 1.
- `dout`  output  WIDTH: assembled word; bit 0 is the first bit received (LSB first).
- `dout_valid`  output  1: `dout` holds an unconsumed word.
- `dout_ready`  input  1: consumer accepts `dout` on an edge where `dout_valid` and `dout_ready` are both 1.
- `overrun`  output  1: sticky; a completed word was dropped.
- `parity_err`  output  1: parity result for the word currently on `dout`.

## Operation
- Reset values: `dout`=0, `dout_valid`=0, `overrun`=0, `parity_err`=0, bit counter=0, shift register=0, FSM=`COLLECT`.
- FSM states: `COLLECT` and `PARITY`. `PARITY` exists only when the parity feature is compiled in.
- In `COLLECT`, each qualified bit shifts into the shift register at position `bitcnt`, and `bitcnt` increments.
- On the WIDTH-th qualified bit:
  - parity compiled out: the word completes; `bitcnt` returns to 0.
  - parity compiled in: go to `PARITY`.
- In `PARITY`, the next qualified bit is the parity bit. The word then completes, `bitcnt` returns to 0 and the FSM returns to `COLLECT`.
- Word completion writes the holding register:
  - `dout_valid`=0: load `dout`, set `dout_valid`=1.
  - `dout_valid`=1 and `dout_ready`=1 on the same edge: load the new word; `dout_valid` stays 1; no overrun.
  - `dout_valid`=1 and `dout_ready`=0: drop the new word; `dout` is unchanged; set `overrun`=1.
- `overrun` clears only on reset.
- Accept without a completion on the same edge: `dout_valid` goes to 0. `dout` keeps its old value.
- `din_valid`=0: no state change except the output handshake.
- Reset asserted mid-word: the partial word is discarded. The next qualified bit after release is bit 0.
- Bit counter width is `$clog2(WIDTH+1)`; it never exceeds WIDTH.

## Timing
- The last data bit (or the parity bit) is sampled on edge N. `dout` and `dout_valid` are updated by edge N, so they are visible in the cycle after N. Latency from last bit to valid is 1 edge, with no extra pipeline stage.
- Sustained rate: one word per WIDTH qualified cycles (WIDTH+1 with parity). With `dout_ready` held at 1, no overrun occurs at full rate.
- `dout_ready` is sampled only at the rising edge. There is no combinational path from `dout_ready` or `din` to any output.
- All outputs are registered.

## Configuration
- Macro: `SERIAL_DESER_PARITY_EN`.
- Defined:
  - one even-parity bit follows each word; the `PARITY` state exists.
  - `parity_err` is loaded with `(^word) ^ parity_bit` together with `dout`.
  - `parity_err` is held until the next load.
  - A dropped (overrun) word does not affect `parity_err`.
- Undefined: no parity bit is expected; `PARITY` state is absent; `parity_err` is tied to 0.

## Structure
- Shared package `serial_deser_pkg`:
  - FSM state typedef (`COLLECT`, `PARITY`).
  - constant function for counter width.
  - parameter range check constants.
- One sub-module, `deser_shift_reg`: WIDTH-bit indexed shift register with load enable and clear. The FSM, counter, holding register and flags stay in the top level.

## Test plan
- Reset: hold `reset`=0 while toggling `din`/`din_valid` → all outputs 0. After release, the first qualified bit lands in `dout[0]`.
- Single word: WIDTH=8; send 0xA5 LSB first (1,0,1,0,0,1,0,1) with `din_valid` gaps inserted; `dout_ready`=1 → `dout`=0xA5, `dout_valid`=1 for one cycle, `overrun`=0.
- Backpressure: `dout_ready`=0; send 0x3C then 0xFF → `dout`=0x3C held, `overrun`=1 after the 8th bit of 0xFF. Raise `dout_ready` → `dout_valid` falls; `overrun` stays 1.
- Simultaneous: `dout` holds 0x11 and `dout_ready` rises on the same edge as the last bit of 0x22 → `dout`=0x22, `dout_valid` stays 1, `overrun`=0.
- Reset mid-word: send 3 bits, pulse `reset` low, then send 0x81 → `dout`=0x81, not corrupted.
- Parity (macro defined):
  - 0x03 with parity bit 0 → `parity_err`=0.
  - 0x07 with parity bit 0 → `parity_err`=1.
